// File: rtl/wasca_pio_pkg.sv
// Shared constants and helpers for the wasca input PIO: register word
// addresses, edge-type encodings and counter sizing.
package wasca_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Bits needed for a counter that must hold the value max_count.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

    // Cycles after reset release during which edges are suppressed.
    function automatic int prime_len(input int sync_stages, input int debounce_cycles,
                                     input bit debounce_en);
        return sync_stages + 1 + (debounce_en ? debounce_cycles : 0);
    endfunction

endpackage

// File: rtl/wasca_pio_debounce.sv
// One input bit: SYNC_STAGES-deep synchronizer, followed by a stability filter
// when WASCA_PIO_DEBOUNCE_EN is defined (pass-through otherwise).
module wasca_pio_debounce
    import wasca_pio_pkg::*;
#(
    parameter int SYNC_STAGES = 2
`ifdef WASCA_PIO_DEBOUNCE_EN
    , parameter int DEBOUNCE_CYCLES = 16
`endif
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_val_s;

    // Synchronizer shift chain; the oldest stage is the usable value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], din};
        end
    end

    assign sync_val_s = sync_r[SYNC_STAGES-1];

`ifdef WASCA_PIO_DEBOUNCE_EN
    localparam int CW = cnt_width(DEBOUNCE_CYCLES);

    logic [CW-1:0] cnt_r;
    logic          filt_r;

    // Accept a new level only after it has differed from filt for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r  <= '0;
            filt_r <= 1'b0;
        end else if (sync_val_s == filt_r) begin
            cnt_r  <= '0;
        end else if (cnt_r == CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt_r  <= '0;
            filt_r <= sync_val_s;
        end else begin
            cnt_r  <= cnt_r + CW'(1);
        end
    end

    assign dout = filt_r;
`else
    assign dout = sync_val_s;
`endif

endmodule

// File: rtl/wasca_pio_in_edge.sv
// Avalon-MM input PIO with per-bit edge capture and maskable level irq.
// Optional input debounce is built in when WASCA_PIO_DEBOUNCE_EN is defined.
module wasca_pio_in_edge
    import wasca_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int EDGE_TYPE       = 0,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

`ifdef WASCA_PIO_DEBOUNCE_EN
    localparam bit DB_EN = 1'b1;
`else
    localparam bit DB_EN = 1'b0;
`endif
    localparam int PRIME_LEN = prime_len(SYNC_STAGES, DEBOUNCE_CYCLES, DB_EN);
    localparam int PW        = cnt_width(PRIME_LEN);

    logic [WIDTH-1:0] filt_s;
    logic [WIDTH-1:0] prev_r;
    logic [WIDTH-1:0] mask_r;
    logic [WIDTH-1:0] cap_r;
    logic [WIDTH-1:0] event_s;
    logic [WIDTH-1:0] clr_s;
    logic [WIDTH-1:0] mask_next_s;
    logic [WIDTH-1:0] cap_next_s;
    logic [31:0]      rdata_next_s;
    logic [31:0]      wdata_unused_s;
    logic [PW-1:0]    prime_cnt_r;
    logic             primed_s;
    logic             wr_s;
    logic             rd_s;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        wasca_pio_debounce #(
            .SYNC_STAGES(SYNC_STAGES)
`ifdef WASCA_PIO_DEBOUNCE_EN
            , .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`endif
        ) u_deb (
            .clk    (clk),
            .reset_n(reset_n),
            .din    (in_port[gi]),
            .dout   (filt_s[gi])
        );
    end

    assign wr_s           = chipselect & ~write_n;
    assign rd_s           = chipselect & write_n;
    assign primed_s       = (prime_cnt_r == PW'(PRIME_LEN));
    assign wdata_unused_s = writedata;

    // Priming counter: holds off capture until the filtered inputs are settled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prime_cnt_r <= '0;
        end else if (!primed_s) begin
            prime_cnt_r <= prime_cnt_r + PW'(1);
        end else begin
            prime_cnt_r <= prime_cnt_r;
        end
    end

    // Edge event selection.
    always_comb begin
        event_s = '0;
        case (EDGE_TYPE)
            EDGE_RISE: event_s = filt_s & ~prev_r;
            EDGE_FALL: event_s = ~filt_s & prev_r;
            default:   event_s = filt_s ^ prev_r;
        endcase
    end

    // Register-write decode and next capture state; a same-cycle event beats a clear.
    always_comb begin
        clr_s       = '0;
        mask_next_s = mask_r;
        if (wr_s) begin
            case (address)
                ADDR_IRQMASK: mask_next_s = writedata[WIDTH-1:0];
                ADDR_EDGECAP: clr_s       = writedata[WIDTH-1:0];
                default:      clr_s       = '0;
            endcase
        end else begin
            clr_s = '0;
        end
        cap_next_s = (primed_s ? event_s : '0) | (cap_r & ~clr_s);
    end

    // Read mux; anything but a selected read returns zero.
    always_comb begin
        rdata_next_s = '0;
        if (rd_s) begin
            case (address)
                ADDR_DATA:    rdata_next_s = 32'(filt_s);
                ADDR_IRQMASK: rdata_next_s = 32'(mask_r);
                ADDR_EDGECAP: rdata_next_s = 32'(cap_r);
                default:      rdata_next_s = '0;
            endcase
        end else begin
            rdata_next_s = '0;
        end
    end

    // Architectural state and registered read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_r   <= '0;
            mask_r   <= '0;
            cap_r    <= '0;
            readdata <= '0;
        end else begin
            prev_r   <= filt_s;
            mask_r   <= mask_next_s;
            cap_r    <= cap_next_s;
            readdata <= rdata_next_s;
        end
    end

    assign irq = |(cap_r & mask_r);

endmodule

// File: tb/tb_wasca_pio_in_edge.sv
// Self-checking bench: rise/fall/any instances share stimulus and are compared
// each cycle against a history-based model, plus directed literal checks.
module tb_wasca_pio_in_edge;

    localparam int W = 4;
    localparam int S = 2;
    localparam int D = 16;
`ifdef WASCA_PIO_DEBOUNCE_EN
    localparam int DB = D;
`else
    localparam int DB = 0;
`endif
    localparam int LAT    = S + 1 + DB;
    localparam int SETTLE = LAT + 3;
    localparam int HMAX   = 8192;

    logic        clk       = 1'b0;
    logic        reset_n   = 1'b1;
    logic        cs        = 1'b0;
    logic        write_n   = 1'b1;
    logic [1:0]  address   = 2'd0;
    logic [31:0] writedata = 32'd0;
    logic [3:0]  in_port   = 4'hF;
    logic [31:0] rdata [3];
    logic        irq_w [3];

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        wasca_pio_in_edge #(
            .WIDTH(W), .EDGE_TYPE(g), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)
        ) u_dut (
            .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs),
            .write_n(write_n), .writedata(writedata), .in_port(in_port),
            .readdata(rdata[g]), .irq(irq_w[g])
        );
    end

    // Model: histories indexed by clock edge number since reset release.
    logic [3:0]  ih [HMAX];
    logic [3:0]  sh [HMAX];
    logic [3:0]  fh [HMAX];
    int          n = 0;
    logic [3:0]  cap_m [3];
    logic [3:0]  mask_m = 4'h0;
    logic [31:0] rd_m [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] s_at(input int j);
        return (j < 1) ? 4'h0 : sh[j];
    endfunction

    function automatic logic [3:0] f_at(input int j);
        return (j < 1) ? 4'h0 : fh[j];
    endfunction

    task automatic model_step();
        int         k;
        logic [3:0] sy, fl, fp, pp, clr, sj;
        logic [3:0] evs [3];
        bit         primed, wr, rd, flip;
        k = n + 1;
        if (k >= HMAX) begin
            $display("FAIL model_history actual=%0d expected<%0d", k, HMAX);
            $fatal(1);
        end
        ih[k] = in_port;
        sy    = (k - (S - 1) >= 1) ? ih[k - (S - 1)] : 4'h0;
        sh[k] = sy;
        fp    = f_at(k - 1);
        pp    = f_at(k - 2);
`ifdef WASCA_PIO_DEBOUNCE_EN
        fl = fp;
        for (int i = 0; i < W; i++) begin
            flip = 1'b1;
            for (int j = 1; j <= D; j++) begin
                sj = s_at(k - j);
                if (sj[i] == fp[i]) flip = 1'b0;
            end
            if (flip) fl[i] = ~fp[i];
        end
`else
        fl = sy;
`endif
        fh[k]  = fl;
        evs[0] = fp & ~pp;
        evs[1] = ~fp & pp;
        evs[2] = fp ^ pp;
        primed = (k - 1) >= LAT;
        wr     = cs && !write_n;
        rd     = cs && write_n;
        clr    = (wr && address == 2'd3) ? writedata[3:0] : 4'h0;
        for (int e = 0; e < 3; e++) begin
            if (!rd)                 rd_m[e] = 32'd0;
            else if (address == 2'd0) rd_m[e] = {28'd0, fp};
            else if (address == 2'd2) rd_m[e] = {28'd0, mask_m};
            else if (address == 2'd3) rd_m[e] = {28'd0, cap_m[e]};
            else                      rd_m[e] = 32'd0;
            cap_m[e] = (primed ? evs[e] : 4'h0) | (cap_m[e] & ~clr);
        end
        if (wr && address == 2'd2) mask_m = writedata[3:0];
        n = k;
    endtask

    initial begin
        for (int e = 0; e < 3; e++) begin
            cap_m[e] = 4'h0;
            rd_m[e]  = 32'd0;
        end
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                n      = 0;
                mask_m = 4'h0;
                for (int e = 0; e < 3; e++) begin
                    cap_m[e] = 4'h0;
                    rd_m[e]  = 32'd0;
                end
            end else begin
                model_step();
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                for (int e = 0; e < 3; e++) begin
                    chk($sformatf("cmp_readdata_e%0d", e), rdata[e], rd_m[e]);
                    chk($sformatf("cmp_irq_e%0d", e), {31'd0, irq_w[e]},
                        {31'd0, |(cap_m[e] & mask_m)});
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cs = 1'b1; write_n = 1'b0; address = a; writedata = d;
        tick();
        cs = 1'b0; write_n = 1'b1; writedata = 32'd0;
    endtask

    task automatic rd_lit(input logic [1:0] a, input int sel, input logic [31:0] exp,
                          input string name);
        cs = 1'b1; write_n = 1'b1; address = a;
        @(negedge clk);
        chk(name, rdata[sel], exp);
        #1;
        cs = 1'b0;
    endtask

    // Apply new inputs while reading EDGECAP every cycle; capture must land exactly at LAT.
    task automatic lat_check(input logic [3:0] new_in, input int sel, input logic [3:0] expv,
                             input string name);
        in_port = new_in;
        cs = 1'b1; write_n = 1'b1; address = 2'd3;
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge clk);
            chk($sformatf("%s_k%0d", name, k), rdata[sel], (k == LAT + 1) ? {28'd0, expv} : 32'd0);
        end
        #1;
        cs = 1'b0;
    endtask

    initial begin
        #1 reset_n = 1'b0;
        #1 cmp_en  = 1'b1;
        repeat (3) tick();
        reset_n = 1'b1;

        // Inputs held high through reset produce no capture.
        repeat (10 + SETTLE) tick();
        rd_lit(2'd0, 0, 32'h0000_000F, "reset_data");
        rd_lit(2'd3, 0, 32'd0, "reset_edgecap_rise");
        rd_lit(2'd3, 2, 32'd0, "reset_edgecap_any");
        chk("reset_irq", {31'd0, irq_w[2]}, 32'd0);

        in_port = 4'h0;
        repeat (SETTLE) tick();
        wr(2'd3, 32'h0000_000F);
        repeat (2) tick();
        lat_check(4'h5, 0, 4'h5, "rise_latency");
        chk("irq_masked", {31'd0, irq_w[0]}, 32'd0);
        wr(2'd2, 32'h0000_0004);
        chk("irq_unmasked", {31'd0, irq_w[0]}, 32'd1);

        wr(2'd3, 32'h0000_0004);
        chk("irq_after_clear", {31'd0, irq_w[0]}, 32'd0);
        rd_lit(2'd3, 0, 32'h0000_0001, "partial_clear");
        in_port = 4'h4;
        repeat (SETTLE) tick();
        wr(2'd3, 32'h0000_0001);
        rd_lit(2'd3, 0, 32'd0, "bit0_cleared");
        in_port = 4'h5;
        repeat (LAT - 1) tick();
        wr(2'd3, 32'h0000_0001);
        rd_lit(2'd3, 0, 32'h0000_0001, "set_beats_clear");

        wr(2'd3, 32'h0000_000F);
        in_port = 4'hD;
        repeat (SETTLE + 15) tick();
        rd_lit(2'd3, 2, 32'h0000_0008, "any_rise_bit3");
        rd_lit(2'd3, 1, 32'd0, "fall_no_rise_bit3");
        wr(2'd3, 32'h0000_0008);
        in_port = 4'h5;
        repeat (SETTLE + 15) tick();
        rd_lit(2'd3, 2, 32'h0000_0008, "any_fall_bit3");
        rd_lit(2'd3, 1, 32'h0000_0008, "fall_bit3");

        rd_lit(2'd1, 0, 32'd0, "reserved_read");
        wr(2'd0, 32'hFFFF_FFFF);
        rd_lit(2'd0, 0, 32'h0000_0005, "data_unchanged");
        rd_lit(2'd2, 0, 32'h0000_0004, "mask_unchanged");
        wr(2'd2, 32'hFFFF_FFFF);
        rd_lit(2'd2, 0, 32'h0000_000F, "mask_width_limit");

`ifdef WASCA_PIO_DEBOUNCE_EN
        wr(2'd3, 32'h0000_000F);
        in_port = 4'h7;
        repeat (10) tick();
        in_port = 4'h5;
        repeat (SETTLE) tick();
        rd_lit(2'd0, 0, 32'h0000_0005, "glitch_data");
        rd_lit(2'd3, 0, 32'd0, "glitch_edgecap");
        lat_check(4'h7, 0, 4'h2, "debounce_latency");
        in_port = 4'h5;
        repeat (SETTLE) tick();
`endif

        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 7) == 0) in_port = 4'($urandom);
            cs        = ($urandom_range(0, 3) != 0);
            write_n   = 1'($urandom_range(0, 1));
            address   = 2'($urandom_range(0, 3));
            writedata = $urandom;
            tick();
        end
        cs = 1'b0; write_n = 1'b1;

        // Reset mid-operation with an active irq.
        wr(2'd2, 32'h0000_000F);
        wr(2'd3, 32'h0000_000F);
        in_port = ~in_port;
        repeat (SETTLE) tick();
        chk("pre_reset_irq", {31'd0, irq_w[2]}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_reset_irq", {31'd0, irq_w[2]}, 32'd0);
        chk("mid_reset_readdata", rdata[2], 32'd0);
        repeat (3) tick();
        reset_n = 1'b1;
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 5) == 0) in_port = 4'($urandom);
            cs        = ($urandom_range(0, 2) != 0);
            write_n   = 1'($urandom_range(0, 1));
            address   = 2'($urandom_range(0, 3));
            writedata = $urandom;
            tick();
        end
        cs = 1'b0; write_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
